// File: rtl/udp_pkg.sv
// Shared types for the UDP transmit scheduler: data/length widths and the
// one-hot state encoding used by the scheduler FSM.
package udp_pkg;

  localparam int LEN_W  = 16;
  localparam int DATA_W = 8;

  typedef logic [LEN_W-1:0]  len_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [7:0] {
    S_IDLE     = 8'b0000_0001,
    S_ARP_REQ  = 8'b0000_0010,
    S_ARP_SEND = 8'b0000_0100,
    S_ARP_WAIT = 8'b0000_1000,
    S_GRANT    = 8'b0001_0000,
    S_GEN_REQ  = 8'b0010_0000,
    S_WRITE    = 8'b0100_0000,
    S_GAP      = 8'b1000_0000
  } state_t;

endpackage

// File: rtl/udp_tx_scheduler_if.sv
// MAC-side bundle of the scheduler: UDP request/ack, TX RAM write port,
// frame length, back-pressure and ARP control.
interface udp_tx_scheduler_if;
  import udp_pkg::*;

  logic  udp_tx_req;
  logic  udp_ram_data_req;
  data_t ram_wr_data;
  logic  ram_wr_en;
  len_t  udp_send_data_length;
  logic  almost_full;
  logic  mac_send_end;
  logic  arp_request_req;
  logic  arp_found;
  logic  mac_not_exist;

  // Scheduler side
  modport master (
    output udp_tx_req, ram_wr_data, ram_wr_en, udp_send_data_length, arp_request_req,
    input  udp_ram_data_req, almost_full, mac_send_end, arp_found, mac_not_exist
  );

  // MAC side
  modport slave (
    input  udp_tx_req, ram_wr_data, ram_wr_en, udp_send_data_length, arp_request_req,
    output udp_ram_data_req, almost_full, mac_send_end, arp_found, mac_not_exist
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester favoured on
// a tie; it moves away from the last served requester on the update strobe.
module rr_arb2 (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic [1:0] served,
  output logic [1:0] winner
);

  logic ptr;

  // Tie-break pointer: after serving 0 favour 1, after serving 1 favour 0.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (update && (served != 2'b00)) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of block ordering.
      ptr <= served[0];
    end
  end

  // Winner selection: a lone requester always wins, a tie goes to ptr.
  always_comb begin
    // NOTE: default assigned first so no path leaves winner unassigned,
    // which would otherwise infer a latch.
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = ptr ? 2'b10 : 2'b01;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Shares the MAC UDP transmit path between two payload sources: resolves
// the destination MAC via ARP when needed, arbitrates round-robin, forwards
// the owner's bytes into the MAC TX RAM and enforces an inter-frame gap.
module udp_tx_scheduler
  import udp_pkg::*;
#(
  parameter int IFG_CYCLES  = 90,
  parameter int ARP_TIMEOUT = 125000000
) (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  len_t       len0,
  input  len_t       len1,
  input  data_t      wr_data0,
  input  data_t      wr_data1,
  input  logic       wr_en0,
  input  logic       wr_en1,
  input  logic       wr_last0,
  input  logic       wr_last1,
  output logic [1:0] grant,
  output logic [1:0] src_start,
  output logic [1:0] done,
  output logic       busy,
  udp_tx_scheduler_if.master mac
);

  localparam logic [31:0] GAP_LAST = 32'(IFG_CYCLES - 1);
  localparam logic [31:0] ARP_LAST = 32'(ARP_TIMEOUT - 1);

  state_t      state, state_next;
  logic [31:0] tmr;
  len_t        byte_cnt;
  len_t        len_q;
  data_t       wr_data_q;
  logic        wr_en_q;
  logic [1:0]  arb_winner;
  logic        arb_update;
  len_t        win_len;
  logic        own_en;
  logic        own_last;
  data_t       own_data;

  // Only the current owner's byte stream is visible; the other is ignored.
  assign own_en   = (grant[0] & wr_en0) | (grant[1] & wr_en1);
  assign own_last = (grant[0] & wr_last0) | (grant[1] & wr_last1);
  assign own_data = grant[1] ? wr_data1 : wr_data0;
  assign win_len  = arb_winner[1] ? len1 : len0;

  // The pointer advances once per frame, as the gap ends.
  assign arb_update = (state == S_GAP) && (state_next == S_IDLE);

  rr_arb2 u_arb (
    .gmii_tx_clk (gmii_tx_clk),
    .rst_n       (rst_n),
    .req         (req),
    .update      (arb_update),
    .served      (grant),
    .winner      (arb_winner)
  );

  assign busy                     = (state != S_IDLE);
  assign mac.udp_tx_req           = (state == S_GEN_REQ);
  assign mac.arp_request_req      = (state == S_ARP_REQ);
  assign mac.ram_wr_data          = wr_data_q;
  assign mac.ram_wr_en            = wr_en_q;
  assign mac.udp_send_data_length = len_q;

  // Next-state logic of the scheduler FSM.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:
        if ((req != 2'b00) && !mac.almost_full)
          state_next = mac.mac_not_exist ? S_ARP_REQ : S_GRANT;
      S_ARP_REQ:
        state_next = S_ARP_SEND;
      S_ARP_SEND:
        if (mac.mac_send_end) state_next = S_ARP_WAIT;
      S_ARP_WAIT:
        if (mac.arp_found)      state_next = S_IDLE;
        else if (tmr == ARP_LAST) state_next = S_ARP_REQ;
      S_GRANT:
        if (arb_winner == 2'b00) state_next = S_IDLE;
        else if (win_len == '0)  state_next = S_GAP;
        else                     state_next = S_GEN_REQ;
      S_GEN_REQ:
        if (mac.udp_ram_data_req) state_next = S_WRITE;
      S_WRITE:
        if (own_en && own_last) state_next = S_GAP;
      S_GAP:
        if (tmr == GAP_LAST) state_next = S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
  end

  // State, timers, latched frame context and registered outputs.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tmr       <= '0;
      byte_cnt  <= '0;
      len_q     <= '0;
      grant     <= 2'b00;
      src_start <= 2'b00;
      done      <= 2'b00;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state     <= state_next;
      src_start <= 2'b00;
      done      <= 2'b00;
      wr_en_q   <= 1'b0;

      // Shared timer for ARP_WAIT and GAP, restarted on every state entry.
      if ((state_next == state) && ((state == S_ARP_WAIT) || (state == S_GAP)))
        tmr <= tmr + 32'd1;
      else
        tmr <= '0;

      if (state == S_GRANT) begin
        grant    <= arb_winner;
        len_q    <= win_len;
        byte_cnt <= '0;
        if ((arb_winner != 2'b00) && (win_len == '0))
          done <= arb_winner;
      end

      if ((state == S_GEN_REQ) && mac.udp_ram_data_req)
        src_start <= grant;

      if ((state == S_WRITE) && own_en) begin
        wr_data_q <= own_data;
        if (byte_cnt < len_q) begin
          wr_en_q  <= 1'b1;
          byte_cnt <= byte_cnt + 16'd1;
        end
        if (own_last)
          done <= grant;
      end

      if (arb_update)
        grant <= 2'b00;
    end
  end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed bench for udp_tx_scheduler: arbitration order, byte forwarding,
// length clipping, zero length, back-pressure, ARP retry and async reset.
module tb_udp_tx_scheduler;
  import udp_pkg::*;

  localparam int IFG = 90;
  localparam int ARP_TO = 100;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  len_t       len0, len1;
  data_t      wr_data0, wr_data1;
  logic       wr_en0, wr_en1, wr_last0, wr_last1;
  logic [1:0] grant, src_start, done;
  logic       busy;

  udp_tx_scheduler_if mac_if ();

  udp_tx_scheduler #(.IFG_CYCLES(IFG), .ARP_TIMEOUT(ARP_TO)) dut (
    .gmii_tx_clk (clk),
    .rst_n       (rst_n),
    .req         (req),
    .len0        (len0),
    .len1        (len1),
    .wr_data0    (wr_data0),
    .wr_data1    (wr_data1),
    .wr_en0      (wr_en0),
    .wr_en1      (wr_en1),
    .wr_last0    (wr_last0),
    .wr_last1    (wr_last1),
    .grant       (grant),
    .src_start   (src_start),
    .done        (done),
    .busy        (busy),
    .mac         (mac_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Event counters and write log, sampled on the falling edge.
  int tx_cyc = 0, arp_cnt = 0, src_cnt = 0, done0_cnt = 0, done1_cnt = 0;
  int excl_viol = 0, pulse_viol = 0;
  data_t wr_log[$];
  logic [1:0] prev_src = 2'b00, prev_done = 2'b00;
  logic prev_arp = 1'b0;

  always @(negedge clk) begin
    if (mac_if.udp_tx_req) tx_cyc++;
    if (mac_if.arp_request_req) arp_cnt++;
    if (src_start != 2'b00) src_cnt++;
    if (done[0]) done0_cnt++;
    if (done[1]) done1_cnt++;
    if (mac_if.ram_wr_en) wr_log.push_back(mac_if.ram_wr_data);
    if (int'(mac_if.udp_tx_req) + int'(mac_if.arp_request_req) + int'(src_start != 2'b00) > 1)
      excl_viol++;
    if (((prev_src & src_start) != 2'b00) || ((prev_done & done) != 2'b00) ||
        (prev_arp && mac_if.arp_request_req))
      pulse_viol++;
    prev_src  = src_start;
    prev_done = done;
    prev_arp  = mac_if.arp_request_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_req(output bit ok);
    int n = 0;
    while (!mac_if.udp_tx_req && n < 200) begin n++; tick(); end
    ok = mac_if.udp_tx_req;
  endtask

  task automatic ack_and_start(input int who, output bit ok);
    int n = 0;
    mac_if.udp_ram_data_req = 1'b1;
    tick();
    mac_if.udp_ram_data_req = 1'b0;
    while (src_start[who] !== 1'b1 && n < 10) begin n++; tick(); end
    ok = src_start[who];
  endtask

  // Owner streams n bytes (base+i), wr_last at index last_at; the other
  // source drives noise with wr_last set that must be ignored.
  task automatic stream(input int who, input int n, input int last_at);
    for (int i = 0; i < n; i++) begin
      if (who == 0) begin
        wr_data0 = 8'(8'h10 + i); wr_en0 = 1'b1; wr_last0 = (i == last_at);
        wr_data1 = 8'hEE;         wr_en1 = 1'b1; wr_last1 = 1'b1;
      end else begin
        wr_data1 = 8'(8'h40 + i); wr_en1 = 1'b1; wr_last1 = (i == last_at);
        wr_data0 = 8'hEE;         wr_en0 = 1'b1; wr_last0 = 1'b1;
      end
      tick();
    end
    wr_en0 = 1'b0; wr_en1 = 1'b0; wr_last0 = 1'b0; wr_last1 = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 1000) begin cycles++; tick(); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 2'b00; len0 = '0; len1 = '0;
    wr_data0 = '0; wr_data1 = '0; wr_en0 = 0; wr_en1 = 0; wr_last0 = 0; wr_last1 = 0;
    mac_if.udp_ram_data_req = 0; mac_if.almost_full = 0; mac_if.mac_send_end = 0;
    mac_if.arp_found = 0; mac_if.mac_not_exist = 0;
    tick(); tick(); tick();
    checks++; if ({grant, src_start, done} !== 6'b0) begin failures++;
      $display("FAIL reset_grant_start_done: got %b expected 000000", {grant, src_start, done}); end
    checks++; if ({busy, mac_if.udp_tx_req, mac_if.arp_request_req, mac_if.ram_wr_en} !== 4'b0) begin failures++;
      $display("FAIL reset_ctrl: got %b expected 0000", {busy, mac_if.udp_tx_req, mac_if.arp_request_req, mac_if.ram_wr_en}); end
    checks++; if (mac_if.ram_wr_data !== 8'h00 || mac_if.udp_send_data_length !== 16'h0) begin failures++;
      $display("FAIL reset_data_len: got %h/%h expected 00/0000", mac_if.ram_wr_data, mac_if.udp_send_data_length); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_g[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    bit ok;
    int gap;
    req = 2'b11; len0 = 16'd8; len1 = 16'd8;
    for (int f = 0; f < 4; f++) begin
      int who = (exp_g[f] == 2'b01) ? 0 : 1;
      wr_log.delete();
      wait_tx_req(ok);
      checks++; if (!ok || grant !== exp_g[f]) begin failures++;
        $display("FAIL contention_grant%0d: got %b (req seen %0d) expected %b", f, grant, ok, exp_g[f]); end
      ack_and_start(who, ok);
      stream(who, 8, 7);
      if (f == 3) req = 2'b00;
      wait_idle(gap);
      checks++; if (gap < IFG || gap >= 1000 || wr_log.size() != 8) begin failures++;
        $display("FAIL contention_gap%0d: got gap %0d writes %0d expected gap>=%0d writes 8", f, gap, wr_log.size(), IFG); end
    end
  endtask

  task automatic test_single();
    bit ok;
    int gap, d0;
    d0 = done0_cnt;
    wr_log.delete();
    req = 2'b01; len0 = 16'd20;
    wait_tx_req(ok);
    checks++; if (!ok || grant !== 2'b01 || mac_if.udp_send_data_length !== 16'd20) begin failures++;
      $display("FAIL single_grant_len: got %b/%0d expected 01/20", grant, mac_if.udp_send_data_length); end
    tick(); tick(); tick();
    checks++; if (mac_if.udp_tx_req !== 1'b1) begin failures++;
      $display("FAIL single_txreq_hold: got %b expected 1", mac_if.udp_tx_req); end
    mac_if.udp_ram_data_req = 1'b1;
    tick();
    mac_if.udp_ram_data_req = 1'b0;
    checks++; if (src_start !== 2'b01 || mac_if.udp_tx_req !== 1'b0) begin failures++;
      $display("FAIL single_src_start: got %b txreq %b expected 01 txreq 0", src_start, mac_if.udp_tx_req); end
    for (int i = 0; i < 20; i++) begin
      wr_data0 = 8'(8'h10 + i); wr_en0 = 1'b1; wr_last0 = (i == 19);
      if (i == 0) begin
        checks++; if (mac_if.ram_wr_en !== 1'b0) begin failures++;
          $display("FAIL single_lag: got ram_wr_en %b expected 0 before edge", mac_if.ram_wr_en); end
      end
      tick();
      checks++; if (mac_if.ram_wr_en !== 1'b1 || mac_if.ram_wr_data !== 8'(8'h10 + i)) begin failures++;
        $display("FAIL single_byte%0d: got en %b data %h expected en 1 data %h", i, mac_if.ram_wr_en, mac_if.ram_wr_data, 8'(8'h10 + i)); end
    end
    wr_en0 = 1'b0; wr_last0 = 1'b0;
    checks++; if (done !== 2'b01) begin failures++;
      $display("FAIL single_done: got %b expected 01", done); end
    req = 2'b00;
    wait_idle(gap);
    checks++; if (gap != IFG) begin failures++;
      $display("FAIL single_gap: got %0d expected %0d", gap, IFG); end
    checks++; if (done0_cnt - d0 != 1 || wr_log.size() != 20) begin failures++;
      $display("FAIL single_counts: got done %0d writes %0d expected 1/20", done0_cnt - d0, wr_log.size()); end
  endtask

  task automatic test_overrun();
    bit ok;
    int gap;
    wr_log.delete();
    req = 2'b01; len0 = 16'd4;
    wait_tx_req(ok);
    ack_and_start(0, ok);
    stream(0, 6, 5);
    req = 2'b00;
    wait_idle(gap);
    checks++; if (wr_log.size() != 4) begin failures++;
      $display("FAIL overrun_count: got %0d expected 4", wr_log.size()); end
    else begin
      checks++; if (wr_log[0] !== 8'h10 || wr_log[3] !== 8'h13) begin failures++;
        $display("FAIL overrun_data: got %h..%h expected 10..13", wr_log[0], wr_log[3]); end
    end
  endtask

  task automatic test_underrun();
    bit ok;
    int gap, d0;
    d0 = done0_cnt;
    wr_log.delete();
    req = 2'b01; len0 = 16'd4;
    wait_tx_req(ok);
    ack_and_start(0, ok);
    stream(0, 2, 1);
    checks++; if (done !== 2'b01 || busy !== 1'b1) begin failures++;
      $display("FAIL underrun_done: got done %b busy %b expected 01/1", done, busy); end
    req = 2'b00;
    wait_idle(gap);
    checks++; if (wr_log.size() != 2 || gap != IFG || done0_cnt - d0 != 1) begin failures++;
      $display("FAIL underrun_counts: got writes %0d gap %0d done %0d expected 2/%0d/1", wr_log.size(), gap, done0_cnt - d0, IFG); end
  endtask

  task automatic test_zero_len();
    int n = 0, gap, tx0, s0, d1;
    tx0 = tx_cyc; s0 = src_cnt; d1 = done1_cnt;
    wr_log.delete();
    req = 2'b10; len1 = 16'd0;
    while (done[1] !== 1'b1 && n < 20) begin n++; tick(); end
    checks++; if (done !== 2'b10 || grant !== 2'b10) begin failures++;
      $display("FAIL zero_done: got done %b grant %b expected 10/10", done, grant); end
    req = 2'b00;
    wait_idle(gap);
    checks++; if (tx_cyc != tx0 || src_cnt != s0 || wr_log.size() != 0 || done1_cnt - d1 != 1) begin failures++;
      $display("FAIL zero_no_tx: got txreq %0d start %0d writes %0d done %0d expected 0/0/0/1", tx_cyc - tx0, src_cnt - s0, wr_log.size(), done1_cnt - d1); end
    checks++; if (gap != IFG) begin failures++;
      $display("FAIL zero_gap: got %0d expected %0d", gap, IFG); end
  endtask

  task automatic test_back_pressure();
    bit ok;
    int gap, tx0;
    tx0 = tx_cyc;
    mac_if.almost_full = 1'b1;
    req = 2'b01; len0 = 16'd3;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (busy !== 1'b0 || grant !== 2'b00 || tx_cyc != tx0) begin failures++;
      $display("FAIL bp_hold: got busy %b grant %b txreq %0d expected 0/00/0", busy, grant, tx_cyc - tx0); end
    mac_if.almost_full = 1'b0;
    wait_tx_req(ok);
    checks++; if (!ok) begin failures++;
      $display("FAIL bp_release: got no udp_tx_req expected udp_tx_req"); end
    ack_and_start(0, ok);
    stream(0, 3, 2);
    req = 2'b00;
    wait_idle(gap);
  endtask

  task automatic test_arp();
    bit ok;
    int n = 0, gap, a0, tx0;
    a0 = arp_cnt; tx0 = tx_cyc;
    mac_if.mac_not_exist = 1'b1;
    req = 2'b01; len0 = 16'd4;
    while (!mac_if.arp_request_req && n < 20) begin n++; tick(); end
    checks++; if (mac_if.arp_request_req !== 1'b1) begin failures++;
      $display("FAIL arp_req: got %b expected 1", mac_if.arp_request_req); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (busy !== 1'b1 || arp_cnt - a0 != 1 || tx_cyc != tx0) begin failures++;
      $display("FAIL arp_send_hold: got busy %b arp %0d txreq %0d expected 1/1/0", busy, arp_cnt - a0, tx_cyc - tx0); end
    mac_if.mac_send_end = 1'b1; tick(); mac_if.mac_send_end = 1'b0;
    n = 0;
    while (!mac_if.arp_request_req && n < 300) begin n++; tick(); end
    checks++; if (n != ARP_TO) begin failures++;
      $display("FAIL arp_timeout: got %0d expected %0d", n, ARP_TO); end
    tick();
    mac_if.mac_send_end = 1'b1; tick(); mac_if.mac_send_end = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    mac_if.arp_found = 1'b1; mac_if.mac_not_exist = 1'b0;
    tick();
    mac_if.arp_found = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL arp_found_idle: got busy %b expected 0", busy); end
    wait_tx_req(ok);
    checks++; if (!ok || grant !== 2'b01 || arp_cnt - a0 != 2) begin failures++;
      $display("FAIL arp_grant: got grant %b arp %0d expected 01/2", grant, arp_cnt - a0); end
    ack_and_start(0, ok);
    stream(0, 4, 3);
    req = 2'b00;
    wait_idle(gap);
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int gap;
    req = 2'b10; len1 = 16'd10;
    wait_tx_req(ok);
    ack_and_start(1, ok);
    wr_data1 = 8'h55; wr_en1 = 1'b1; wr_last1 = 1'b0;
    tick(); tick(); tick();
    checks++; if (mac_if.ram_wr_en !== 1'b1 || grant !== 2'b10) begin failures++;
      $display("FAIL midwrite_active: got en %b grant %b expected 1/10", mac_if.ram_wr_en, grant); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({grant, src_start, done, busy, mac_if.udp_tx_req, mac_if.arp_request_req, mac_if.ram_wr_en} !== 10'b0 ||
                  mac_if.ram_wr_data !== 8'h00 || mac_if.udp_send_data_length !== 16'h0) begin failures++;
      $display("FAIL midwrite_reset_outputs: got %b %h %h expected all zero", {grant, src_start, done, busy, mac_if.udp_tx_req, mac_if.arp_request_req, mac_if.ram_wr_en}, mac_if.ram_wr_data, mac_if.udp_send_data_length); end
    wr_en1 = 1'b0;
    tick(); tick();
    req = 2'b11; len0 = 16'd2; len1 = 16'd2;
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 && grant !== 2'b00) begin failures++;
      $display("FAIL midwrite_idle: got busy %b grant %b expected idle", busy, grant); end
    wait_tx_req(ok);
    checks++; if (!ok || grant !== 2'b01) begin failures++;
      $display("FAIL midwrite_first_grant: got %b expected 01", grant); end
    ack_and_start(0, ok);
    stream(0, 2, 1);
    req = 2'b00;
    wait_idle(gap);
  endtask

  task automatic test_protocol();
    checks++; if (excl_viol != 0) begin failures++;
      $display("FAIL exclusive_req_start: got %0d overlaps expected 0", excl_viol); end
    checks++; if (pulse_viol != 0) begin failures++;
      $display("FAIL pulse_width: got %0d long pulses expected 0", pulse_viol); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_overrun();
    test_underrun();
    test_zero_len();
    test_back_pressure();
    test_arp();
    test_reset_mid_write();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/udp_tx_scheduler.md
UDP_TX_SCHEDULER -- requirements
Module: udp_tx_scheduler

Interface
REQ-001 Parameter IFG_CYCLES, default 90: idle cycles enforced after each frame.
REQ-002 Parameter ARP_TIMEOUT, default 125000000: ARP_WAIT cycles before an ARP retry.
REQ-003 gmii_tx_clk  in  1  sole clock, all logic rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req  in  2  per-requester frame pending, level, held until done.
REQ-006 len0, len1  in  16  payload byte count of requester 0/1, stable while req set.
REQ-007 wr_data0, wr_data1  in  8  payload byte from requester 0/1.
REQ-008 wr_en0, wr_en1  in  1  byte valid from requester 0/1.
REQ-009 wr_last0, wr_last1  in  1  final byte marker, qualified by wr_en.
REQ-010 grant  out  2  one-hot current owner, 0 when none.
REQ-011 src_start  out  2  one-cycle pulse to owner: begin streaming bytes.
REQ-012 done  out  2  one-cycle pulse when the owner's frame is finished or dropped.
REQ-013 udp_tx_req, udp_ram_data_req  out, in  1  MAC UDP request/acknowledge.
REQ-014 ram_wr_data, ram_wr_en  out  8, 1  payload write port into the MAC TX RAM.
REQ-015 udp_send_data_length  out  16  latched length of the granted frame.
REQ-016 almost_full, mac_send_end  in  1  MAC TX RAM back-pressure / MAC frame sent.
REQ-017 arp_request_req, arp_found, mac_not_exist  out, in, in  1  ARP control.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 States SHALL be IDLE, ARP_REQ, ARP_SEND, ARP_WAIT, GRANT, GEN_REQ, WRITE, GAP (one-hot).
REQ-020 IDLE SHALL advance only when req!=0 and almost_full=0: to ARP_REQ if mac_not_exist, else to GRANT.
REQ-021 ARP_REQ SHALL last one cycle with arp_request_req=1, then go to ARP_SEND.
REQ-022 ARP_SEND SHALL hold until mac_send_end, then go to ARP_WAIT.
REQ-023 ARP_WAIT SHALL go to IDLE on arp_found; it SHALL go to ARP_REQ when its counter reaches ARP_TIMEOUT-1; arp_found wins on the same cycle.
REQ-024 GRANT SHALL select round-robin: the requester not served last wins when both are pending; after reset, requester 0 has priority.
REQ-025 GRANT SHALL latch grant and udp_send_data_length from the winner's len.
REQ-026 If the latched length is 0, the block SHALL pulse done, skip transmission and go to GAP.
REQ-027 GEN_REQ SHALL hold udp_tx_req=1 until udp_ram_data_req=1, then pulse src_start for the owner and enter WRITE.
REQ-028 In WRITE, the owner's wr_data/wr_en SHALL appear on ram_wr_data/ram_wr_en one cycle later (registered); the non-owner's inputs are ignored.
REQ-029 A 16-bit byte counter SHALL count forwarded bytes; bytes beyond the latched length SHALL be dropped (ram_wr_en=0).
REQ-030 An owner wr_en&wr_last SHALL end WRITE: pulse done and go to GAP, including early last (underrun).
REQ-031 GAP SHALL hold for IFG_CYCLES cycles, update the round-robin pointer, then return to IDLE.
REQ-032 udp_tx_req, arp_request_req and src_start SHALL be mutually exclusive, and no output pulse SHALL exceed one cycle except udp_tx_req.
REQ-033 A req deassertion during WRITE SHALL NOT abort the frame.

Reset
REQ-034 Asynchronous assertion SHALL force IDLE at any state, including mid-WRITE.
REQ-035 During reset, all outputs SHALL be 0, all counters 0, and the round-robin pointer SHALL be 0.
REQ-036 After release, the first arbitration SHALL favour requester 0.

Structure
REQ-037 State encodings, and the widths for length (16) and data (8), SHALL reside in the shared package udp_pkg.
REQ-038 One sub-module, rr_arb2 (2-way round-robin with a pointer update strobe), is natural; all other logic is inline.

Verification
REQ-039 Single request: req=01, len0=20, mac_not_exist=0 -> udp_tx_req until ack, 20 ram_wr_en pulses lagging source by 1, one done[0] pulse, then 90 idle cycles.
REQ-040 Contention: req=11 held, len0=len1=8 -> grant sequence 01,10,01,10; each frame is separated by at least 90 cycles.
REQ-041 ARP path: mac_not_exist=1, req=01 -> arp_request_req pulse, wait for mac_send_end; with ARP_TIMEOUT=100 and no arp_found -> retry after 100 cycles; on arp_found -> IDLE then GRANT.
REQ-042 Overrun/underrun: len0=4 with 6 bytes streamed -> exactly 4 writes; len0=4 with wr_last on byte 2 -> 2 writes, done[0], GAP.
REQ-043 Zero length / back-pressure: len1=0 -> done[1] with no udp_tx_req; almost_full=1 with req set -> stays IDLE until almost_full drops.
REQ-044 Reset asserted mid-WRITE -> all outputs 0 immediately, IDLE after release, grant favours requester 0.
